// File: rtl/main_mem_burst.sv
// main_mem_burst: line-oriented main memory model with fixed read/write latency.
// A request is accepted only in IDLE. The line is then moved one word per cycle
// between the storage array and an internal line register. A one-cycle gnt
// pulse marks completion, and the following cycle is always IDLE.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for rd_req/wr_req; request fields latched on accept
// RD_WAIT | read latency padding before the word transfer
// RD_XFER | one word per cycle from storage into the read latch
// WR_WAIT | write latency padding (skipped when the padding is zero)
// WR_XFER | one word per cycle into storage, gated by the latched mask
// DONE    | gnt cycle; rd_line already updated for reads
module main_mem_burst #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_CYCLE      = 10,
  parameter int WR_CYCLE      = 10
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ADDR_LEN-1:0]                          addr,
  input  logic                                         rd_req,
  input  logic                                         wr_req,
  input  logic [DATA_WIDTH*(1<<LINE_ADDR_LEN)-1:0]     wr_line,
  input  logic [(1<<LINE_ADDR_LEN)-1:0]                wr_mask,
  output logic [DATA_WIDTH*(1<<LINE_ADDR_LEN)-1:0]     rd_line,
  output logic                                         gnt,
  output logic                                         busy
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int LINE_BITS = DATA_WIDTH * LINE_SIZE;
  localparam int MEM_WORDS = 1 << (ADDR_LEN + LINE_ADDR_LEN);
  // Latency is counted from the IDLE cycle in which the request is seen,
  // so the busy cycles before DONE are the padding plus LINE_SIZE transfers.
  localparam int RD_WAIT_N = RD_CYCLE - LINE_SIZE - 1;
  localparam int WR_WAIT_N = WR_CYCLE - LINE_SIZE - 1;
  localparam int CNT_W     = $clog2(RD_CYCLE + WR_CYCLE + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT_N - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = (WR_WAIT_N > 0) ? CNT_W'(WR_WAIT_N - 1) : '0;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = LINE_ADDR_LEN'(LINE_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_XFER = 3'd2,
    WR_WAIT = 3'd3,
    WR_XFER = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                               state_q;
  logic [CNT_W-1:0]                     cnt_q;
  logic [LINE_ADDR_LEN-1:0]             idx_q;
  logic [ADDR_LEN-1:0]                  addr_q;
  logic [LINE_BITS-1:0]                 line_q;
  logic [LINE_SIZE-1:0]                 mask_q;
  logic [LINE_BITS-1:0]                 latch_q;
  logic [LINE_BITS-1:0]                 latch_d;
  logic [LINE_BITS-1:0]                 rd_line_q;
  logic                                 gnt_q;
  logic                                 busy_q;
  logic [ADDR_LEN+LINE_ADDR_LEN-1:0]    waddr;

  // Storage is deliberately outside the reset domain; it powers up zero in simulation.
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  assign waddr = {addr_q, idx_q};

  // Read latch next value: the current word lands in its slot during RD_XFER.
  always_comb begin
    latch_d = latch_q;
    if (state_q == RD_XFER) begin
      latch_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = mem_q[waddr];
    end
  end

  // Storage write port: one masked word per WR_XFER cycle; an async reset stops it at once.
  always_ff @(posedge clk) begin
    if (state_q == WR_XFER && mask_q[idx_q]) begin
      mem_q[waddr] <= line_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Sequencer FSM with registered gnt/busy/rd_line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      mask_q    <= '0;
      latch_q   <= '0;
      rd_line_q <= '0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      latch_q <= latch_d;
      gnt_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // Read wins a simultaneous request; the write is dropped, not queued.
          if (rd_req) begin
            addr_q  <= addr;
            idx_q   <= '0;
            cnt_q   <= RD_LOAD;
            busy_q  <= 1'b1;
            state_q <= RD_WAIT;
          end else if (wr_req) begin
            addr_q  <= addr;
            line_q  <= wr_line;
            mask_q  <= wr_mask;
            idx_q   <= '0;
            cnt_q   <= WR_LOAD;
            busy_q  <= 1'b1;
            state_q <= (WR_WAIT_N > 0) ? WR_WAIT : WR_XFER;
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RD_XFER;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RD_XFER: begin
          if (idx_q == LAST_IDX) begin
            rd_line_q <= latch_d;
            gnt_q     <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q + LINE_ADDR_LEN'(1);
          end
        end
        WR_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= WR_XFER;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WR_XFER: begin
          if (idx_q == LAST_IDX) begin
            gnt_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + LINE_ADDR_LEN'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_line = rd_line_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;

endmodule

// File: doc/main_mem_burst.md
MAIN_MEM_BURST -- requirements
Module: main_mem_burst

Interface
REQ-001 Parameter LINE_ADDR_LEN, default 3, meaning log2 words per line; LINE_SIZE = 1 << LINE_ADDR_LEN.
REQ-002 Parameter ADDR_LEN, default 8, meaning log2 number of lines.
REQ-003 Parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-004 Parameter RD_CYCLE, default 10, meaning read latency in cycles; constraint RD_CYCLE >= LINE_SIZE + 2.
REQ-005 Parameter WR_CYCLE, default 10, meaning write latency in cycles; constraint WR_CYCLE >= LINE_SIZE + 1.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 addr  input  ADDR_LEN  line address, sampled only at request acceptance.
REQ-010 rd_req  input  1  read-line request.
REQ-011 wr_req  input  1  write-line request.
REQ-012 wr_line  input  DATA_WIDTH x LINE_SIZE  write data, sampled only at acceptance.
REQ-013 wr_mask  input  LINE_SIZE  per-word write enable, sampled only at acceptance.
REQ-014 rd_line  output  DATA_WIDTH x LINE_SIZE  registered read data.
REQ-015 gnt  output  1  one-cycle completion pulse.
REQ-016 busy  output  1  high while a request is in flight, including the gnt cycle.

Function
REQ-017 Storage SHALL be 2^(ADDR_LEN+LINE_ADDR_LEN) words; word address = {line address, word index}; contents zero at time 0 and unaffected by rst.
REQ-018 FSM states SHALL be IDLE, RD_WAIT, RD_XFER, WR_WAIT, WR_XFER, DONE; busy = (state != IDLE).
REQ-019 Acceptance SHALL occur only at a rising edge with state IDLE and rd_req or wr_req high; addr, wr_line and wr_mask are latched at that edge.
REQ-020 If rd_req and wr_req are both high at acceptance, the read SHALL win; the write is not queued.
REQ-021 Requests, addr, wr_line and wr_mask SHALL be ignored while busy; input changes mid-operation have no effect.
REQ-022 Read: RD_WAIT lasts RD_CYCLE-LINE_SIZE-1 cycles, then RD_XFER reads one word per cycle in index order 0..LINE_SIZE-1 into an internal latch, then DONE.
REQ-023 Write: WR_WAIT lasts WR_CYCLE-LINE_SIZE-1 cycles, then WR_XFER writes one word per cycle in index order; words with wr_mask bit 0 are not written.
REQ-024 gnt SHALL be high exactly in the cycle following the (N)th edge after acceptance, N = RD_CYCLE or WR_CYCLE; that cycle is DONE.
REQ-025 rd_line SHALL update from the latch at the edge entering DONE for reads only; it holds its value through writes and idle.
REQ-026 DONE SHALL always go to IDLE at the next edge; a request held high is re-accepted at the edge after that, giving back-to-back operations separated by one IDLE cycle.
REQ-027 A read of a line SHALL return the data of any write to it that completed (gnt) earlier.

Reset
REQ-028 On rst: state IDLE, gnt 0, busy 0, rd_line all zero, latch and counters zero, immediately and asynchronously.
REQ-029 rst mid-write SHALL abort; words already written in WR_XFER remain, remaining words unwritten, no gnt.
REQ-030 rst mid-read SHALL abort with no gnt and rd_line zero.

Verification
REQ-031 Defaults; write line 5 data 0x50..0x57, mask 0xFF at acceptance T -> gnt only in cycle T+10; read line 5 -> gnt 10 cycles after acceptance, rd_line = 0x50..0x57.
REQ-032 Write line 5 data 0xA0..0xA7, mask 0x0F -> subsequent read returns 0xA0..0xA3, 0x54..0x57.
REQ-033 rd_req and wr_req both high, addr 3 -> read performed, line 3 unchanged, exactly one gnt.
REQ-034 rd_req held high 30 cycles, addr 7 -> gnt pulses in cycles T+10 and T+21; addr changed to 9 during busy has no effect on the first read.
REQ-035 Write line 2 with 0x11..0x18, assert rst 1 cycle after entering WR_XFER -> no gnt, busy 0 immediately; read line 2 returns 0x11, 0x12 (or 0x11 only per exact edge), rest zero.
REQ-036 Parameters LINE_ADDR_LEN=2, DATA_WIDTH=16, RD_CYCLE=6, WR_CYCLE=5 -> write/read round-trip matches; gnt latencies 5 and 6.
